// File: rtl/random_gen.sv
// 16-bit Fibonacci LFSR, stepped once every DIV clocks, driving four registered 4-bit outputs; no handshake.
// Define RANDOM_GEN_DISTINCT_EN to make the four outputs pairwise distinct.
module random_gen #(
   parameter logic [15:0] SEED = 16'hACE1,
   parameter int unsigned DIV  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [3:0] rand_one,
   output logic [3:0] rand_two,
   output logic [3:0] rand_three,
   output logic [3:0] rand_four
);

   localparam logic [15:0] INIT    = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] DIV_MAX = 16'(DIV - 1);

   logic [15:0] s;
   logic [15:0] s_next;
   logic [15:0] cnt;
   logic        tick;
   logic        fb;

   // Nibble post-processing applied in front of the output registers.
   function automatic logic [15:0] post(input logic [15:0] raw);
`ifdef RANDOM_GEN_DISTINCT_EN
      logic [3:0] v [4];
      logic       dup;
      for (int i = 0; i < 4; i++) begin
         v[i] = raw[4*i +: 4];
         for (int k = 0; k < 3; k++) begin
            dup = 1'b0;
            for (int j = 0; j < 4; j++) begin
               if (j < i && v[j] == v[i]) dup = 1'b1;
            end
            if (dup) v[i] = v[i] + 4'd1;
         end
      end
      return {v[3], v[2], v[1], v[0]};
`else
      return raw;
`endif
   endfunction

   assign fb     = s[15] ^ s[13] ^ s[12] ^ s[10];
   // A corrupted all-zero state would lock the LFSR, so reload the seed instead.
   assign s_next = (s == 16'h0000) ? INIT : {s[14:0], fb};
   assign tick   = (cnt == DIV_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s   <= INIT;
         cnt <= 16'h0000;
         {rand_four, rand_three, rand_two, rand_one} <= post(INIT);
      end else if (tick) begin
         s   <= s_next;
         cnt <= 16'h0000;
         {rand_four, rand_three, rand_two, rand_one} <= post(s_next);
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_random_gen.sv
// Directed bench for random_gen: reset values, first steps, prescaler, seed edge cases, period and async reset.
module tb_random_gen;

   logic        clk;
   logic        rst_n;
   logic [15:0] oa, ob, oc, od;
   int          checks;
   int          errors;
   int          n;
   logic        zero_seen;

   random_gen dut_a (.clk(clk), .rst_n(rst_n),
      .rand_one(oa[3:0]), .rand_two(oa[7:4]), .rand_three(oa[11:8]), .rand_four(oa[15:12]));
   random_gen #(.DIV(4)) dut_b (.clk(clk), .rst_n(rst_n),
      .rand_one(ob[3:0]), .rand_two(ob[7:4]), .rand_three(ob[11:8]), .rand_four(ob[15:12]));
   random_gen #(.SEED(16'h1111)) dut_c (.clk(clk), .rst_n(rst_n),
      .rand_one(oc[3:0]), .rand_two(oc[7:4]), .rand_three(oc[11:8]), .rand_four(oc[15:12]));
   random_gen #(.SEED(16'h0000)) dut_d (.clk(clk), .rst_n(rst_n),
      .rand_one(od[3:0]), .rand_two(od[7:4]), .rand_three(od[11:8]), .rand_four(od[15:12]));

`ifdef RANDOM_GEN_DISTINCT_EN
   localparam logic [15:0] C_RST  = 16'h4321;
   localparam logic [15:0] C_STEP = 16'h5423;
   localparam logic [15:0] D_RST  = 16'h3201;
`else
   localparam logic [15:0] C_RST  = 16'h1111;
   localparam logic [15:0] C_STEP = 16'h2223;
   localparam logic [15:0] D_RST  = 16'h0001;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      zero_seen = 1'b0;
      rst_n     = 1'b0;
      step();
      step();

      check("rst_a", {16'h0, oa}, {16'h0, 16'hACE1});
      check("rst_b", {16'h0, ob}, {16'h0, 16'hACE1});
      check("rst_c", {16'h0, oc}, {16'h0, C_RST});
      check("rst_d", {16'h0, od}, {16'h0, D_RST});

      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         check($sformatf("div4_e%0d", e), {16'h0, ob},
               {16'h0, (e < 4) ? 16'hACE1 : ((e < 8) ? 16'h59C3 : 16'hB387)});
         if (e == 1) begin
            check("a_step1", {16'h0, oa}, {16'h0, 16'h59C3});
            check("c_step1", {16'h0, oc}, {16'h0, C_STEP});
         end
         if (e == 2) check("a_step2", {16'h0, oa}, {16'h0, 16'hB387});
         if (e == 3) check("a_step3", {16'h0, oa}, {16'h0, 16'h670F});
      end

      // Fresh start, then count ticks until the seed state reappears.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n = 0;
      for (int i = 1; i <= 70000; i++) begin
         step();
         n = i;
         if (dut_a.s == 16'h0000) zero_seen = 1'b1;
         if (dut_a.s == 16'hACE1) break;
      end
      check("period", n, 65535);
      check("never_zero", {31'h0, zero_seen}, 32'h0);

      for (int i = 0; i < 100; i++) step();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_a", {16'h0, oa}, {16'h0, 16'hACE1});
      check("async_rst_b", {16'h0, ob}, {16'h0, 16'hACE1});
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rel_a_step1", {16'h0, oa}, {16'h0, 16'h59C3});
      check("rel_b_hold", {16'h0, ob}, {16'h0, 16'hACE1});
      step();
      step();
      check("rel_b_hold3", {16'h0, ob}, {16'h0, 16'hACE1});
      step();
      check("rel_b_tick4", {16'h0, ob}, {16'h0, 16'h59C3});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
